led_blinker_multi: RTL

Parametrised multi-channel LED driver, the generalised successor of the single fixed-rate board blinker. Each of `NUM_CH` channels independently runs in OFF, ON, BLINK or ONESHOT mode with a runtime-programmable half-period in clock cycles. Sits between the board-level control logic, which writes per-channel configuration, and the FPGA LED pins.

---
 rtl/led_pkg.sv | 11 +
 rtl/led_channel.sv | 100 ++++++++++
 rtl/led_blinker_multi.sv | 44 ++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared mode encoding for the multi-channel LED driver.
package led_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF     = 2'd0;
  localparam mode_t MODE_ON      = 2'd1;
  localparam mode_t MODE_BLINK   = 2'd2;
  localparam mode_t MODE_ONESHOT = 2'd3;

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode/half-period/counter state with registered led and done outputs.
module led_channel
  import led_pkg::*;
#(
  parameter int               CNT_W        = 32,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(50000000),
  parameter mode_t            DEFAULT_MODE = MODE_BLINK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             sync,
  input  mode_t            cfg_mode,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             led,
  output logic             done
);

  mode_t            r_mode, w_mode_nxt;
  logic [CNT_W-1:0] r_half, w_half_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_led, w_led_nxt;
  logic             r_done, w_done_nxt;
  logic [CNT_W-1:0] w_half_eff;
  logic             w_last;

  // A stored half-period of 0 behaves as 1, so the terminal count is always reachable.
  assign w_half_eff = (r_half == '0) ? CNT_W'(1) : r_half;
  assign w_last     = (r_cnt == w_half_eff - CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode <= DEFAULT_MODE;
      r_half <= DEFAULT_HALF;
      r_cnt  <= '0;
      r_led  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_mode <= w_mode_nxt;
      r_half <= w_half_nxt;
      r_cnt  <= w_cnt_nxt;
      r_led  <= w_led_nxt;
      r_done <= w_done_nxt;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    w_mode_nxt = r_mode;
    w_half_nxt = r_half;
    w_cnt_nxt  = r_cnt;
    w_led_nxt  = r_led;
    w_done_nxt = 1'b0;
    if (wr) begin
      // A write restarts the channel and overrides both sync and a ONESHOT expiry.
      w_mode_nxt = cfg_mode;
      w_half_nxt = cfg_half;
      w_cnt_nxt  = '0;
      w_led_nxt  = (cfg_mode != MODE_OFF);
    end else if (sync && (r_mode == MODE_BLINK)) begin
      w_cnt_nxt = '0;
      w_led_nxt = 1'b1;
    end else begin
      case (r_mode)
        MODE_OFF: begin
          w_cnt_nxt = '0;
          w_led_nxt = 1'b0;
        end
        MODE_ON: begin
          w_cnt_nxt = '0;
          w_led_nxt = 1'b1;
        end
        MODE_BLINK: begin
          if (w_last) begin
            w_cnt_nxt = '0;
            w_led_nxt = ~r_led;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          if (w_last) begin
            w_mode_nxt = MODE_OFF;
            w_cnt_nxt  = '0;
            w_led_nxt  = 1'b0;
            w_done_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            w_led_nxt = 1'b1;
          end
        end
      endcase
    end
  end

  assign led  = r_led;
  assign done = r_done;

endmodule

// File: rtl/led_blinker_multi.sv
// Multi-channel LED driver: decodes the config channel select and fans out to NUM_CH channels.
module led_blinker_multi
  import led_pkg::*;
#(
  parameter int               NUM_CH       = 4,
  parameter int               CNT_W        = 32,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(50000000),
  parameter mode_t            DEFAULT_MODE = MODE_BLINK,
  localparam int              CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  mode_t             cfg_mode,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic              sync,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] done
);

  logic [NUM_CH-1:0] w_wr;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range channel selects match no index and are silently dropped.
    assign w_wr[i] = cfg_we && (cfg_ch == CH_W'(i));

    led_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF),
      .DEFAULT_MODE (DEFAULT_MODE)
    ) u_channel (
      .clk      (clk),
      .reset    (reset),
      .wr       (w_wr[i]),
      .sync     (sync),
      .cfg_mode (cfg_mode),
      .cfg_half (cfg_half),
      .led      (led[i]),
      .done     (done[i])
    );
  end

endmodule
